if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch front end for the 5-stage pipelined CPU. Owns the PC and issues reads to the instruction RAM, which returns data one cycle after a request. Buffers returned words with their PC+4 in a small queue and presents them to the IF/ID pipeline register under a valid/ready handshake. Handles branch redirects from the MEM stage and stops fetching at the end-of-program word 32'hFFFF_FFFF.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- DEPTH, 2, fetch-queue entries; power of two, ≥2

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge
- RST  in  1  reset, synchronous and active-high
- imem_req  out  1  read request this cycle
- imem_addr  out  32  byte address of the request (current PC)
- imem_rdata  in  32  instruction word, valid exactly one cycle after imem_req
- redirect  in  1  taken branch/jump resolved in MEM
- redirect_pc  in  32  target address; bits [1:0] forced to 0 internally
- inst  out  32  instruction at queue head; 0 when inst_valid=0
- PCplus4  out  32  PC+4 of that instruction; 0 when inst_valid=0
- inst_valid  out  1  queue non-empty
- id_ready  in  1  IF/ID accepts the head this cycle (deasserted on ID stall)
- halted  out  1  end-of-program word fetched; no further requests

## Operation
- State: pc register, inflight flag with its PC, squash flag, queue of {inst, PCplus4} with occupancy count, halted flag.
- pop = inst_valid & id_ready.
- Issue: imem_req = !RST & !redirect & !halted & !halt_pending & (occ + inflight − pop < DEPTH). On issue, pc ← pc+4 (32-bit wrap) and inflight ← 1 with the issued PC.
- Return: in the cycle after an issue, imem_rdata is pushed as {imem_rdata, issued_pc+4} unless squashed.
- Halt: a pushed word equal to 32'hFFFF_FFFF is still enqueued. halted ← 1 on the next edge. halt_pending blocks an issue in the same cycle the word returns. Instructions already enqueued still drain.
- Redirect has priority over everything:
  - queue cleared and occ ← 0;
  - an in-flight response arriving next cycle is discarded (squash);
  - a response arriving this cycle is not pushed;
  - pc ← redirect_pc & ~3 and halted ← 0;
  - no request that cycle; fetch resumes at the target on the next cycle.
- Simultaneous push and pop: both take effect; occ unchanged.
- Queue never overflows. A push with occ==DEPTH and no pop is a design error and is flagged by an assertion in simulation.

## Timing
- Reset values (after an edge with RST=1): pc=RESET_PC, occ=0, inflight=0, squash=0, halted=0, inst_valid=0, inst=0, PCplus4=0. imem_req=0 while RST is high.
- RST asserted mid-operation discards queue contents and any in-flight response on the next edge.
- First request in the first cycle after RST deasserts. inst_valid rises 2 cycles after the request.
- Throughput is 1 instruction/cycle with id_ready held high.
- Redirect in cycle N → request to the target in N+1 → target inst_valid in N+3 (3-cycle branch bubble at fetch).
- With id_ready low: the queue fills to DEPTH and then imem_req drops. Requests resume in the cycle a pop occurs.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs fetch_count (32 bit, counts pops) and stall_cycles (32 bit, counts cycles with inst_valid & !id_ready). Both counters clear on RST and wrap at 2^32.
- FETCH_PERF_CNT_EN undefined: those ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset then free-run, imem returns addr>>2 as data, id_ready=1 → inst 0,1,2,… with PCplus4 4,8,12,…; first inst_valid 2 cycles after RST falls; one instruction per cycle thereafter.
- Hold id_ready=0 for 6 cycles → occ reaches 2, imem_req=0 while full, no instruction lost or duplicated after release.
- Redirect to 32'h0000_0103 with one word in flight and two queued → queue empties next cycle, in-flight word dropped, next request addr 32'h0000_0100, inst_valid 3 cycles after redirect.
- Word 32'hFFFF_FFFF at addr 0x10 → it is delivered, halted=1, no request beyond 0x14; a later redirect to 0x40 clears halted and resumes fetch at 0x40.
- RST pulsed while queue full and request in flight → all outputs at reset values next cycle, fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN: 10 pops and 4 stalled cycles → fetch_count=10, stall_cycles=4.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, one-cycle imem read, {inst, PC+4} queue, redirect and halt.
// Define FETCH_PERF_CNT_EN to add the fetch_count / stall_cycles performance counters.

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] PCplus4,
    output logic        inst_valid,
    input  logic        id_ready,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_cycles
`endif
);

    localparam int unsigned PtrW     = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW     = PtrW + 1;
    localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;

    // Architectural state
    logic [31:0]     pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic            squash_q, squash_d;
    logic            halted_q, halted_d;
    logic [CntW-1:0] occ_q, occ_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

    // Queue storage
    logic [31:0] inst_mem_q [DEPTH];
    logic [31:0] pc4_mem_q  [DEPTH];

    // Handshake and issue decisions
    logic          pop;
    logic          push;
    logic          halt_pending;
    logic          room;
    logic [CntW:0] load;

    assign inst_valid = (occ_q != '0);
    assign pop        = inst_valid & id_ready;

    // The word returning this cycle belongs to last cycle's request; a redirect discards it.
    assign push         = inflight_q & ~squash_q & ~redirect & ~RST;
    assign halt_pending = push & (imem_rdata == HaltWord);

    // Slots already claimed (queued + in flight) once this cycle's pop is accounted for.
    assign load = {1'b0, occ_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    assign room = (load < (CntW + 1)'(DEPTH));

    assign imem_req  = ~RST & ~redirect & ~halted_q & ~halt_pending & room;
    assign imem_addr = pc_q;

    assign halted = halted_q;

    always_comb begin
        inst    = '0;
        PCplus4 = '0;
        if (inst_valid) begin
            inst    = inst_mem_q[rd_ptr_q];
            PCplus4 = pc4_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        squash_d      = 1'b0;
        halted_d      = halted_q | halt_pending;
        occ_d         = occ_q + CntW'(push) - CntW'(pop);
        rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

        if (imem_req) begin
            pc_d          = pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end

        if (redirect) begin
            pc_d       = redirect_pc & ~32'h3;
            inflight_d = 1'b0;
            squash_d   = 1'b1;
            halted_d   = 1'b0;
            occ_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            squash_q      <= 1'b0;
            halted_q      <= 1'b0;
            occ_q         <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
            halted_q      <= halted_d;
            occ_q         <= occ_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Payload needs no reset: the outputs are masked while the queue is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc4_mem_q[wr_ptr_q]  <= inflight_pc_q + 32'd4;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_cycles_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_count_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (pop) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (inst_valid && !id_ready) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

    assert property (@(posedge CLK) disable iff (RST)
        !(push && (occ_q == CntW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: imem model returning addr>>2, scoreboard of {inst, PC+4} per request.

module tb_if_fetch_unit;

    localparam logic [31:0] RstPc = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] inst;
    logic [31:0] PCplus4;
    logic        inst_valid;
    logic        id_ready = 1'b0;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;
`endif

    if_fetch_unit #(
        .RESET_PC (RstPc),
        .DEPTH    (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .PCplus4     (PCplus4),
        .inst_valid  (inst_valid),
        .id_ready    (id_ready),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    logic        halt_en   = 1'b0;
    logic [31:0] halt_addr = 32'h0000_0010;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
        return a >> 2;
    endfunction

    always @(posedge CLK) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] sb_q[$];
    logic [63:0] sb_exp;
    logic [31:0] exp_pc = RstPc;
    logic [31:0] last_req_addr = '0;
    int          halt_seen = 0;

    // Sample at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge CLK);
        if (!inst_valid) begin
            n_cmp++;
            if (inst !== 32'h0 || PCplus4 !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_outputs: inst=%h PCplus4=%h, required 0/0", inst, PCplus4);
            end
        end
        if (inst_valid && id_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: inst=%h PCplus4=%h, required none", inst, PCplus4);
            end else begin
                sb_exp = sb_q.pop_front();
                if ({inst, PCplus4} !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_data: inst=%h PCplus4=%h, required %h/%h",
                             inst, PCplus4, sb_exp[63:32], sb_exp[31:0]);
                end else if (inst == 32'hFFFF_FFFF) begin
                    halt_seen++;
                end
            end
        end
        if (imem_req) begin
            n_cmp++;
            if (imem_addr !== exp_pc) begin
                n_fail++;
                $display("FAIL req_addr: imem_addr=%h, required %h", imem_addr, exp_pc);
            end
            last_req_addr = imem_addr;
            sb_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
            exp_pc = exp_pc + 32'd4;
        end
        if (RST) begin
            sb_q.delete();
            exp_pc = RstPc;
        end else if (redirect) begin
            sb_q.delete();
            exp_pc = redirect_pc & ~32'h3;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        id_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b valid=%b halted=%b, required 0/0/0",
                     imem_req, inst_valid, halted);
        end
        RST = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RstPc) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%h, required 1/%h", imem_req, imem_addr, RstPc);
        end
        tick();
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_valid_early: inst_valid=%b, required 0", inst_valid);
        end
        tick();
        n_cmp++;
        if (inst_valid !== 1'b1 || inst !== 32'h0 || PCplus4 !== 32'h4) begin
            n_fail++;
            $display("FAIL first_inst: valid=%b inst=%h PCplus4=%h, required 1/0/4",
                     inst_valid, inst, PCplus4);
        end
    endtask

    task automatic test_stream();
        id_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (inst_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_rate: cycle %0d inst_valid=%b, required 1", i, inst_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        tick();
        id_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i > 0) begin
                n_cmp++;
                if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_stall: cycle %0d req=%b valid=%b, required 0/1",
                             i, imem_req, inst_valid);
                end
            end
            tick();
        end
        id_ready = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_on_pop: imem_req=%b, required 1", imem_req);
        end
        repeat (6) tick();
    endtask

    task automatic test_redirect();
        tick();
        id_ready = 1'b0;
        repeat (3) tick();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_no_req: imem_req=%b, required 0", imem_req);
        end
        tick();
        redirect = 1'b0;
        id_ready = 1'b1;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redirect_target: valid=%b req=%b addr=%h, required 0/1/00000100",
                     inst_valid, imem_req, imem_addr);
        end
        tick();
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_bubble: inst_valid=%b, required 0", inst_valid);
        end
        tick();
        n_cmp++;
        if (inst_valid !== 1'b1 || inst !== 32'h40 || PCplus4 !== 32'h104) begin
            n_fail++;
            $display("FAIL redirect_first: valid=%b inst=%h PCplus4=%h, required 1/40/104",
                     inst_valid, inst, PCplus4);
        end
        repeat (4) tick();
    endtask

    task automatic test_halt();
        int seen0;
        tick();
        seen0 = halt_seen;
        halt_en = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        tick();
        redirect = 1'b0;
        repeat (12) tick();
        n_cmp++;
        if (halted !== 1'b1 || last_req_addr !== 32'h10 || halt_seen != seen0 + 1 ||
            inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_state: halted=%b last_addr=%h delivered=%0d valid=%b, required 1/10/1/0",
                     halted, last_req_addr, halt_seen - seen0, inst_valid);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_no_req: cycle %0d imem_req=%b, required 0", i, imem_req);
            end
            tick();
        end
        halt_en = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        #1;
        n_cmp++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL halt_resume: halted=%b req=%b addr=%h, required 0/1/00000040",
                     halted, imem_req, imem_addr);
        end
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        tick();
        id_ready = 1'b0;
        repeat (3) tick();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_req: imem_req=%b, required 0", imem_req);
        end
        tick();
        RST = 1'b0;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || PCplus4 !== 32'h0 || halted !== 1'b0 ||
            imem_req !== 1'b1 || imem_addr !== RstPc) begin
            n_fail++;
            $display("FAIL rst_mid_state: valid=%b inst=%h pc4=%h halted=%b req=%b addr=%h, required 0/0/0/0/1/%h",
                     inst_valid, inst, PCplus4, halted, imem_req, imem_addr, RstPc);
        end
        id_ready = 1'b1;
        repeat (8) tick();
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        tick();
        RST = 1'b1;
        id_ready = 1'b1;
        tick();
        RST = 1'b0;
        for (int c = 0; c < 16; c++) begin
            id_ready = (c < 7) || (c >= 11);
            tick();
        end
        id_ready = 1'b0;
        #1;
        n_cmp++;
        if (fetch_count !== 32'd10 || stall_cycles !== 32'd4) begin
            n_fail++;
            $display("FAIL perf_counters: fetch_count=%0d stall_cycles=%0d, required 10/4",
                     fetch_count, stall_cycles);
        end
        id_ready = 1'b1;
        repeat (4) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
